// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state type and the default LO value returned on divide-by-zero.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam int MD_WIDTH = 32;

  // Wide all-ones pattern; each instance truncates it to its own WIDTH.
  localparam logic [63:0] MD_DIVZ_LO = '1;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX,
    MD_DONE
  } md_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 iteration engine for muldiv_unit. Holds the 2*WIDTH accumulator
// and the multiplicand/divisor register. Each step retires one bit.
// Multiply: the multiplier sits in the low half and shifts out to the right.
// Divide: the dividend sits in the low half and shifts out to the left, with
// quotient bits shifting in from the right while the upper half holds the
// partial remainder.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shifted;
  logic [WIDTH:0]     div_diff;
  logic               quo_bit;

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  always_comb begin
    mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff    = div_shifted - {1'b0, opnd};
    quo_bit     = ~div_diff[WIDTH];
    if (is_div) begin
      acc_next = {(quo_bit ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0]),
                  acc[WIDTH-2:0], quo_bit};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Operand load on accept, otherwise advance one iteration when stepping.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{WIDTH{1'b0}}, load_a};
      opnd <= load_b;
    end else if (step) begin
      acc  <= acc_next;
    end
  end

  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide unit for the EX stage. Works on
// magnitudes, applies the result signs in a final FIX cycle, and holds the
// pipeline via stall_req until HI/LO are ready.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int               WIDTH   = MD_WIDTH,
  parameter logic [WIDTH-1:0] DIVZ_LO = WIDTH'(MD_DIVZ_LO)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  md_state_t          state, state_next;
  logic [CNT_W-1:0]   count;
  logic               is_div_q, divz_q, neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   acc_hi, acc_lo;

  logic               in_div, in_signed, sign_a, sign_b, div_by_zero, accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign in_div      = (op == MD_DIV) || (op == MD_DIVU);
  assign in_signed   = (op == MD_MULT) || (op == MD_DIV);
  assign sign_a      = in_signed & operand_a[WIDTH-1];
  assign sign_b      = in_signed & operand_b[WIDTH-1];
  assign mag_a       = sign_a ? -operand_a : operand_a;
  assign mag_b       = sign_b ? -operand_b : operand_b;
  assign div_by_zero = in_div && (operand_b == '0);
  assign accept      = (state == MD_IDLE) && start && !flush;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .step   ((state == MD_RUN) && !flush),
    .is_div (is_div_q),
    .load_a (mag_a),
    .load_b (mag_b),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  // Next-state logic; divide-by-zero skips the iterations entirely.
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (accept) state_next = div_by_zero ? MD_FIX : MD_RUN;
      MD_RUN: begin
        if (flush)                    state_next = MD_IDLE;
        else if (count == LAST_COUNT) state_next = MD_FIX;
      end
      MD_FIX:  state_next = flush ? MD_IDLE : MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // Sign correction of the magnitude result. On divide-by-zero the low half
  // still holds |a|, and re-applying sign_a recovers the original operand_a.
  always_comb begin
    product = {acc_hi, acc_lo};
    if (neg_lo_q) product = -product;
    fix_hi = product[2*WIDTH-1:WIDTH];
    fix_lo = product[WIDTH-1:0];
    if (is_div_q) begin
      if (divz_q) begin
        fix_lo = DIVZ_LO;
        fix_hi = neg_hi_q ? -acc_lo : acc_lo;
      end else begin
        fix_lo = neg_lo_q ? -acc_lo : acc_lo;
        fix_hi = neg_hi_q ? -acc_hi : acc_hi;
      end
    end
  end

  // State, iteration counter, latched op/sign info and the HI/LO registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= MD_IDLE;
      count    <= '0;
      is_div_q <= 1'b0;
      divz_q   <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        is_div_q <= in_div;
        divz_q   <= div_by_zero;
        neg_lo_q <= sign_a ^ sign_b;
        neg_hi_q <= in_div ? sign_a : (sign_a ^ sign_b);
        count    <= '0;
      end else if (state == MD_RUN) begin
        count <= count + 1'b1;
      end
      if ((state == MD_FIX) && !flush) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign stall_req = !reset && (accept || (state == MD_RUN) || (state == MD_FIX));
  assign busy      = (state == MD_RUN) || (state == MD_FIX);
  assign done      = (state == MD_DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
